hazard_ctrl_unit: RTL and testbench

Parametrised successor to the forwarding-only hazard block of the 5-stage RISC-V pipeline. Beyond M/W-to-E forwarding, it detects load-use hazards (stall F/D, bubble E), flushes on taken branches, and sequences multi-cycle execute operations (mul/div) with a registered busy counter that freezes F/D/E and bubbles M. A saturating stall-cycle counter is exposed for performance monitoring. Sits beside the stage modules in pipeline_top and drives their stall/flush inputs.

---
 rtl/hazard_ctrl_unit_pkg.sv | 13 +
 rtl/hazard_ctrl_unit_long_op_sequencer.sv | 64 ++++++
 rtl/hazard_ctrl_unit.sv | 94 +++++++++
 tb/tb_hazard_ctrl_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared encodings for the hazard controller: forwarding mux selects and long-op FSM states.
package hazard_ctrl_unit_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    LOP_IDLE = 1'b0,
    LOP_BUSY = 1'b1
  } lop_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_long_op_sequencer.sv
// Sequences a multi-cycle execute op: stalls for LONG_LAT-1 cycles, then flags the result valid.
// Zero-cycle combinational outputs from registered state; async active-high reset returns to IDLE.
module long_op_sequencer
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int LONG_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic long_op_i,
  output logic long_stall_o,
  output logic long_done_o
);

  // Width is floored at 1 so the LONG_LAT==1 build still has a legal counter.
  localparam int CNT_W = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LONG_LAT > 1) ? (LONG_LAT - 2) : 0);
  localparam bit MULTI = (LONG_LAT > 1);

  lop_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOP_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    long_stall_o = 1'b0;
    long_done_o  = 1'b0;
    case (state_q)
      LOP_IDLE: begin
        if (long_op_i) begin
          if (MULTI) begin
            long_stall_o = 1'b1;
            state_d      = LOP_BUSY;
            cnt_d        = CNT_INIT;
          end else begin
            long_done_o = 1'b1;
          end
        end
      end
      LOP_BUSY: begin
        // LongOpE still high on the final cycle is the same op, so no restart here.
        if (cnt_q != '0) begin
          long_stall_o = 1'b1;
          cnt_d        = cnt_q - CNT_W'(1);
        end else begin
          long_done_o = 1'b1;
          state_d     = LOP_IDLE;
        end
      end
      default: state_d = LOP_IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: M/W forwarding, load-use stall, branch flush, long-op freeze, stall counter.
// All control outputs combinational; StallCount registered and saturating.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LONG_LAT   = 4,
  parameter int STAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic [REG_ADDR_W-1:0] Rs1_E,
  input  logic [REG_ADDR_W-1:0] Rs2_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic [REG_ADDR_W-1:0] RD_W,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  ResultSrcE,
  input  logic                  PCSrcE,
  input  logic                  LongOpE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  LongDoneE,
  output logic [STAT_W-1:0]     StallCount
);

  logic              lw_stall;
  logic              long_stall;
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  long_op_sequencer #(.LONG_LAT(LONG_LAT)) u_seq (
    .clk          (clk),
    .rst          (rst),
    .long_op_i    (LongOpE),
    .long_stall_o (long_stall),
    .long_done_o  (LongDoneE)
  );

  // M is the younger producer, so it wins over W; x0 is never forwarded.
  always_comb begin
    ForwardAE = FWD_RF;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs1_E))      ForwardAE = FWD_M;
    else if (RegWriteW && (RD_W != '0) && (RD_W == Rs1_E)) ForwardAE = FWD_W;
    ForwardBE = FWD_RF;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs2_E))      ForwardBE = FWD_M;
    else if (RegWriteW && (RD_W != '0) && (RD_W == Rs2_E)) ForwardBE = FWD_W;
  end

  assign lw_stall = ResultSrcE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (long_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: default instance plus LONG_LAT=1 and STAT_W=2 variants sharing the same inputs.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic       RegWriteM, RegWriteW, ResultSrcE, PCSrcE, LongOpE;

  logic [1:0]  fa, fb, fa1, fb1, fa2, fb2;
  logic        sf, sd, se, fd, fe, fm, ld;
  logic        sf1, sd1, se1, fd1, fe1, fm1, ld1;
  logic        sf2, sd2, se2, fd2, fe2, fm2, ld2;
  logic [15:0] cnt, cnt1;
  logic [1:0]  cnt2;

  // Flag order: StallF StallD StallE FlushD FlushE FlushM LongDoneE
  logic [6:0] flg, flg1, flg2;
  assign flg  = {sf, sd, se, fd, fe, fm, ld};
  assign flg1 = {sf1, sd1, se1, fd1, fe1, fm1, ld1};
  assign flg2 = {sf2, sd2, se2, fd2, fe2, fm2, ld2};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit dut (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .LongOpE(LongOpE),
    .ForwardAE(fa), .ForwardBE(fb), .StallF(sf), .StallD(sd), .StallE(se),
    .FlushD(fd), .FlushE(fe), .FlushM(fm), .LongDoneE(ld), .StallCount(cnt)
  );

  hazard_ctrl_unit #(.LONG_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .LongOpE(LongOpE),
    .ForwardAE(fa1), .ForwardBE(fb1), .StallF(sf1), .StallD(sd1), .StallE(se1),
    .FlushD(fd1), .FlushE(fe1), .FlushM(fm1), .LongDoneE(ld1), .StallCount(cnt1)
  );

  hazard_ctrl_unit #(.STAT_W(2)) dut_s2 (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .LongOpE(LongOpE),
    .ForwardAE(fa2), .ForwardBE(fb2), .StallF(sf2), .StallD(sd2), .StallE(se2),
    .FlushD(fd2), .FlushE(fe2), .FlushM(fm2), .LongDoneE(ld2), .StallCount(cnt2)
  );

  task automatic clear_inputs();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; LongOpE = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    checks++;
    if (flg !== 7'b0 || fa !== 2'b00 || fb !== 2'b00) begin
      failures++; $display("FAIL reset_outputs got flags=%b fa=%b fb=%b exp 0", flg, fa, fb);
    end
    checks++;
    if (cnt !== 16'd0 || cnt1 !== 16'd0 || cnt2 !== 2'd0) begin
      failures++; $display("FAIL reset_count got %0d/%0d/%0d exp 0", cnt, cnt1, cnt2);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (flg !== 7'b0 || cnt !== 16'd0) begin
      failures++; $display("FAIL post_reset_idle got flags=%b cnt=%0d exp 0", flg, cnt);
    end
  endtask

  task automatic test_forward();
    @(negedge clk);
    RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; Rs1_E = 5; Rs2_E = 9;
    #1;
    checks++;
    if (fa !== 2'b10 || fb !== 2'b00) begin
      failures++; $display("FAIL fwd_m_beats_w got fa=%b fb=%b exp 10 00", fa, fb);
    end
    RD_M = 0;
    #1;
    checks++;
    if (fa !== 2'b01) begin
      failures++; $display("FAIL fwd_w got fa=%b exp 01", fa);
    end
    Rs1_E = 0; RD_W = 0;
    #1;
    checks++;
    if (fa !== 2'b00) begin
      failures++; $display("FAIL fwd_x0 got fa=%b exp 00", fa);
    end
    RD_M = 9; RD_W = 9; RegWriteM = 0;
    #1;
    checks++;
    if (fb !== 2'b01 || fa !== 2'b00) begin
      failures++; $display("FAIL fwd_b_w_only got fa=%b fb=%b exp 00 01", fa, fb);
    end
    RegWriteM = 1; RegWriteW = 0;
    #1;
    checks++;
    if (fb !== 2'b10) begin
      failures++; $display("FAIL fwd_b_m got fb=%b exp 10", fb);
    end
    RegWriteM = 0;
    #1;
    checks++;
    if (fb !== 2'b00) begin
      failures++; $display("FAIL fwd_b_nowrite got fb=%b exp 00", fb);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    logic [15:0] base;
    @(negedge clk);
    base = cnt;
    ResultSrcE = 1; RD_E = 7; Rs2_D = 7; Rs1_D = 3;
    #1;
    checks++;
    if (flg !== 7'b1100100) begin
      failures++; $display("FAIL load_use_flags got %b exp 1100100", flg);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (flg !== 7'b0 || cnt !== base + 16'd1) begin
      failures++; $display("FAIL load_use_one_cycle got flags=%b cnt=%0d exp 0 %0d", flg, cnt, base + 16'd1);
    end
    ResultSrcE = 1; RD_E = 0; Rs1_D = 0; Rs2_D = 0;
    #1;
    checks++;
    if (flg !== 7'b0) begin
      failures++; $display("FAIL load_use_x0 got %b exp 0", flg);
    end
    ResultSrcE = 1; RD_E = 4; Rs1_D = 4;
    #1;
    checks++;
    if (flg !== 7'b1100100) begin
      failures++; $display("FAIL load_use_rs1 got %b exp 1100100", flg);
    end
    clear_inputs();
  endtask

  task automatic test_long_op();
    logic [15:0] base;
    logic [6:0]  exp;
    @(negedge clk);
    base = cnt;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      LongOpE = 1; ResultSrcE = 1; RD_E = 2; Rs1_D = 2;
      #1;
      exp = (c < 3) ? 7'b1110010 : 7'b1100101;
      // Final cycle releases long stall; the lwStall inputs then take effect.
      checks++;
      if (flg !== exp) begin
        failures++; $display("FAIL long_op_cycle%0d got %b exp %b", c, flg, exp);
      end
      checks++;
      if (flg1 !== 7'b1100101) begin
        failures++; $display("FAIL long_lat1_cycle%0d got %b exp 1100101", c, flg1);
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (cnt !== base + 16'd4 || flg !== 7'b0) begin
      failures++; $display("FAIL long_op_count got cnt=%0d flags=%b exp %0d 0", cnt, flg, base + 16'd4);
    end
    LongOpE = 1;
    #1;
    checks++;
    if (flg !== 7'b1110010) begin
      failures++; $display("FAIL long_op_reissue got %b exp 1110010", flg);
    end
    do_reset();
  endtask

  task automatic test_branch();
    @(negedge clk);
    PCSrcE = 1; ResultSrcE = 1; RD_E = 7; Rs1_D = 7;
    #1;
    checks++;
    if (flg !== 7'b0001100) begin
      failures++; $display("FAIL branch_over_lw got %b exp 0001100", flg);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    LongOpE = 1;
    @(negedge clk);
    #1;
    checks++;
    if (flg !== 7'b1110010) begin
      failures++; $display("FAIL busy_before_rst got %b exp 1110010", flg);
    end
    rst = 1'b1; LongOpE = 0;
    #1;
    checks++;
    if (flg !== 7'b0 || cnt !== 16'd0) begin
      failures++; $display("FAIL rst_mid_busy got flags=%b cnt=%0d exp 0 0", flg, cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      LongOpE = 1;
      #1;
      checks++;
      if (flg !== ((c < 3) ? 7'b1110010 : 7'b0000001)) begin
        failures++; $display("FAIL restart_cycle%0d got %b", c, flg);
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (cnt !== 16'd3) begin
      failures++; $display("FAIL restart_count got %0d exp 3", cnt);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp2;
    do_reset();
    ResultSrcE = 1; RD_E = 6; Rs2_D = 6;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp2 = (k < 3) ? 2'(k) : 2'd3;
      checks++;
      if (cnt2 !== exp2 || cnt !== 16'(k)) begin
        failures++; $display("FAIL saturate_k%0d got s2=%0d main=%0d exp %0d %0d", k, cnt2, cnt, exp2, k);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_long_op();
    test_branch();
    test_reset_mid_busy();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
